digital_clock_core: RTL and testbench
=====================================

DIGITAL_CLOCK_CORE -- requirements
Module: digital_clock_core

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1, meaning the number of accepted tick_en pulses per one-second advance (range 1..65535).
REQ-002 The block SHALL have parameter RST_HOUR, default 0, meaning the binary hour (0..23) loaded on reset.
REQ-003 The block SHALL have parameter ALARM_SEC, default 0, meaning the seconds value at which the alarm compare fires (0..59).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port tick_en, input, 1 bit: count-enable strobe, sampled every clk.
REQ-007 The block SHALL have port mode_24, input, 1 bit: display mode, 1 = 24-hour, 0 = 12-hour.
REQ-008 The block SHALL have port load_en, input, 1 bit: load request strobe.
REQ-009 The block SHALL have ports load_hour, load_min and load_sec, input, 5/6/6 bits: binary time to load.
REQ-010 The block SHALL have port alarm_en, input, 1 bit: alarm enable.
REQ-011 The block SHALL have ports alarm_hour and alarm_min, input, 5/6 bits: binary alarm time in 24-hour form.
REQ-012 The block SHALL have ports sec_1, sec_2, min_1, min_2, hour_1 and hour_2, output, 4 bits each: BCD units (_1) and tens (_2) digits.
REQ-013 The block SHALL have port pm, output, 1 bit: 1 when the internal hour is 12..23.
REQ-014 The block SHALL have port sec_oc, output, 1 bit: one-cycle pulse when the seconds field wraps 59->0.
REQ-015 The block SHALL have port min_oc, output, 1 bit: one-cycle pulse when the minutes field wraps 59->0.
REQ-016 The block SHALL have port day_oc, output, 1 bit: one-cycle pulse when the time wraps 23:59:59->00:00:00.
REQ-017 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-018 The block SHALL have port alarm, output, 1 bit: one-cycle alarm pulse.

Function
REQ-019 The block SHALL hold the time internally as binary hour 0..23, min 0..59 and sec 0..59, plus a prescaler count 0..TICK_DIV-1.
REQ-020 On a clk edge with tick_en=1 and load_en=0, the prescaler SHALL increment, and on reaching TICK_DIV-1 it SHALL return to 0 and advance sec by one.
REQ-021 A seconds advance SHALL cascade in the same edge: sec 59->0 increments min; min 59->0 increments hour; hour 23->0.
REQ-022 All three fields SHALL update in one edge, with no ripple latency.
REQ-023 sec_oc, min_oc and day_oc SHALL be registered, asserting in the cycle after the edge on which the wrap occurred, high for exactly one cycle.
REQ-024 min_oc SHALL imply sec_oc, and day_oc SHALL imply min_oc and sec_oc.
REQ-025 The BCD outputs SHALL be a combinational decode of the registered fields, so a field change is visible in the cycle after the edge on which it occurred.
REQ-026 With mode_24=1, hour_2/hour_1 SHALL show 00..23.
REQ-027 With mode_24=0, the hour display SHALL map 0->12, 1..12->01..12 and 13..23->01..11.
REQ-028 pm SHALL be valid in both modes.
REQ-029 Toggling mode_24 SHALL change only the display, never the internal state.
REQ-030 load_en=1 SHALL take priority over tick_en in the same cycle.
REQ-031 If load_hour<=23, load_min<=59 and load_sec<=59, the load SHALL write all three fields and clear the prescaler, with the new time visible in the next cycle.
REQ-032 An accepted load SHALL generate no sec_oc, min_oc or day_oc pulse.
REQ-033 If any load field is out of range, no state SHALL change and load_err SHALL pulse for one cycle in the next cycle.
REQ-034 A rejected load SHALL also discard the tick in that cycle.
REQ-035 alarm SHALL pulse for one cycle, in the cycle after the edge on which the time becomes alarm_hour:alarm_min:ALARM_SEC, when alarm_en=1.
REQ-036 alarm SHALL fire on a counting transition and SHALL NOT fire on a load transition.
REQ-037 alarm SHALL NOT fire again while the time is held with no tick.
REQ-038 An out-of-range alarm_hour or alarm_min SHALL never match.
REQ-039 The time SHALL hold when tick_en=0, with the prescaler retaining its value.

Reset
REQ-040 When rst=1 at a clk edge, the block SHALL set hour=RST_HOUR, min=0, sec=0 and prescaler=0.
REQ-041 When rst=1 at a clk edge, sec_oc, min_oc, day_oc, load_err and alarm SHALL be cleared to 0.
REQ-042 rst SHALL override load_en and tick_en.
REQ-043 A reset asserted mid-count or during a load SHALL discard all pending activity.
REQ-044 In the cycle after reset with RST_HOUR=0, the outputs SHALL read 00:00:00 in 24-hour mode and 12:00:00 with pm=0 in 12-hour mode.

Verification
REQ-045 Scenario 1: TICK_DIV=1, load 23:59:58, then 2 ticks -> time 23:59:59, then 00:00:00, with sec_oc, min_oc and day_oc each high for exactly one cycle on the second wrap.
REQ-046 Scenario 2: TICK_DIV=4, tick_en held high for 8 cycles from 00:00:00 -> sec advances to 01 then 02, with exactly 4 cycles between advances.
REQ-047 Scenario 3: mode_24=0, loads of 00:00:00, 12:30:00 and 13:05:07 -> displays 12:00:00 pm=0, 12:30:00 pm=1, and 01:05:07 pm=1.
REQ-048 Scenario 4: load 24:00:00 or 10:60:00 with tick_en=1 -> load_err is a one-cycle pulse and the time is unchanged, with no advance.
REQ-049 Scenario 5: alarm_en=1, alarm 07:30, ALARM_SEC=0, load 07:29:59, then 1 tick -> alarm pulses once; holding the time with no tick produces no further pulse; loading 07:30:00 directly produces no pulse.
REQ-050 Scenario 6: rst asserted while load_en=1 and tick_en=1 at 10:59:59 -> the next cycle reads RST_HOUR:00:00 and all pulse outputs are 0.

Source files
------------

// File: rtl/digital_clock_core.sv
// Digital clock core: a binary hour/min/sec time-of-day counter with a tick
// prescaler, a validated load, a seconds-resolution alarm, and a BCD display
// that can show either 24-hour or 12-hour time.
module digital_clock_core #(
    parameter int TICK_DIV  = 1,
    parameter int RST_HOUR  = 0,
    parameter int ALARM_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       mode_24,
    input  logic       load_en,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [3:0] sec_1,
    output logic [3:0] sec_2,
    output logic [3:0] min_1,
    output logic [3:0] min_2,
    output logic [3:0] hour_1,
    output logic [3:0] hour_2,
    output logic       pm,
    output logic       sec_oc,
    output logic       min_oc,
    output logic       day_oc,
    output logic       load_err,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [4:0]    hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [PW-1:0] presc;

    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;
    logic [5:0] sec_nx;
    logic [5:0] min_nx;
    logic [4:0] hour_nx;
    logic       load_ok;
    logic       alarm_hit;
    logic [4:0] disp_hour;

    // Split a 0..63 binary value into BCD tens/units digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] units;
        tens  = v / 6'd10;
        units = v % 6'd10;
        return {tens[3:0], units[3:0]};
    endfunction

    // Successor time for a one-second advance, cascading all fields at once.
    always_comb begin
        sec_wrap  = (sec == 6'd59);
        min_wrap  = (min == 6'd59);
        hour_wrap = (hour == 5'd23);
        sec_nx    = sec_wrap ? 6'd0 : sec + 6'd1;
        min_nx    = min;
        hour_nx   = hour;
        if (sec_wrap) begin
            min_nx = min_wrap ? 6'd0 : min + 6'd1;
            if (min_wrap) begin
                hour_nx = hour_wrap ? 5'd0 : hour + 5'd1;
            end
        end
        load_ok   = (load_hour <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
        // An out-of-range alarm time is excluded explicitly so it can never match.
        alarm_hit = alarm_en && (alarm_hour <= 5'd23) && (alarm_min <= 6'd59) &&
                    (hour_nx == alarm_hour) && (min_nx == alarm_min) &&
                    (sec_nx == 6'(ALARM_SEC));
    end

    // Time state, prescaler and registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour     <= 5'(RST_HOUR);
            min      <= 6'd0;
            sec      <= 6'd0;
            presc    <= '0;
            sec_oc   <= 1'b0;
            min_oc   <= 1'b0;
            day_oc   <= 1'b0;
            load_err <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            sec_oc   <= 1'b0;
            min_oc   <= 1'b0;
            day_oc   <= 1'b0;
            load_err <= 1'b0;
            alarm    <= 1'b0;
            if (load_en) begin
                // A load always consumes the cycle's tick, accepted or not.
                if (load_ok) begin
                    hour  <= load_hour;
                    min   <= load_min;
                    sec   <= load_sec;
                    presc <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick_en) begin
                if (presc == PRESC_LAST) begin
                    presc  <= '0;
                    hour   <= hour_nx;
                    min    <= min_nx;
                    sec    <= sec_nx;
                    sec_oc <= sec_wrap;
                    min_oc <= sec_wrap && min_wrap;
                    day_oc <= sec_wrap && min_wrap && hour_wrap;
                    alarm  <= alarm_hit;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // Display decode: 12-hour mode maps 0 to 12 and 13..23 to 1..11.
    always_comb begin
        disp_hour = hour;
        if (!mode_24) begin
            if (hour == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour > 5'd12) begin
                disp_hour = hour - 5'd12;
            end
        end
        {hour_2, hour_1} = to_bcd({1'b0, disp_hour});
        {min_2, min_1}   = to_bcd(min);
        {sec_2, sec_1}   = to_bcd(sec);
        pm               = (hour >= 5'd12);
    end

endmodule

// File: tb/tb_digital_clock_core.sv
// Bench for digital_clock_core: directed scenarios followed by random traffic,
// compared every cycle against a seconds-of-day reference model for two
// differently parameterised instances driven by the same inputs.
module tb_digital_clock_core;

    localparam int TD0 = 1, RH0 = 0, AS0 = 0;
    localparam int TD1 = 4, RH1 = 5, AS1 = 3;

    logic       clk = 1'b0;
    logic       rst, tick_en, mode_24, load_en, alarm_en;
    logic [4:0] load_hour, alarm_hour;
    logic [5:0] load_min, load_sec, alarm_min;

    logic [3:0] s1 [2], s2 [2], m1 [2], m2 [2], h1 [2], h2 [2];
    logic       pm [2], sec_oc [2], min_oc [2], day_oc [2], load_err [2], alarm [2];

    int checks = 0;
    int failures = 0;

    // Reference model state: time as seconds of day plus prescaler count.
    int tod [2];
    int presc [2];
    logic [4:0] exp_flags [2];
    int td [2], rh [2], as_ [2];

    always #5 clk = ~clk;

    digital_clock_core #(.TICK_DIV(TD0), .RST_HOUR(RH0), .ALARM_SEC(AS0)) dut0 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .mode_24(mode_24), .load_en(load_en),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .sec_1(s1[0]), .sec_2(s2[0]), .min_1(m1[0]), .min_2(m2[0]),
        .hour_1(h1[0]), .hour_2(h2[0]), .pm(pm[0]),
        .sec_oc(sec_oc[0]), .min_oc(min_oc[0]), .day_oc(day_oc[0]),
        .load_err(load_err[0]), .alarm(alarm[0])
    );

    digital_clock_core #(.TICK_DIV(TD1), .RST_HOUR(RH1), .ALARM_SEC(AS1)) dut1 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .mode_24(mode_24), .load_en(load_en),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .sec_1(s1[1]), .sec_2(s2[1]), .min_1(m1[1]), .min_2(m2[1]),
        .hour_1(h1[1]), .hour_2(h2[1]), .pm(pm[1]),
        .sec_oc(sec_oc[1]), .min_oc(min_oc[1]), .day_oc(day_oc[1]),
        .load_err(load_err[1]), .alarm(alarm[1])
    );

    function automatic logic [24:0] exp_disp(input int t, input logic m24);
        int h, mi, s, dh;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        dh = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10),
                4'(s / 10), 4'(s % 10), (h >= 12) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [24:0] obs_disp(input int d);
        return {h2[d], h1[d], m2[d], m1[d], s2[d], s1[d], pm[d]};
    endfunction

    function automatic logic [4:0] obs_flags(input int d);
        return {sec_oc[d], min_oc[d], day_oc[d], load_err[d], alarm[d]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge(input int d);
        int target;
        exp_flags[d] = 5'b0;
        if (rst) begin
            tod[d]   = rh[d] * 3600;
            presc[d] = 0;
        end else if (load_en) begin
            if (load_hour <= 23 && load_min <= 59 && load_sec <= 59) begin
                tod[d]   = load_hour * 3600 + load_min * 60 + load_sec;
                presc[d] = 0;
            end else begin
                exp_flags[d][1] = 1'b1;
            end
        end else if (tick_en) begin
            presc[d]++;
            if (presc[d] == td[d]) begin
                presc[d] = 0;
                tod[d]   = (tod[d] + 1) % 86400;
                target   = alarm_hour * 3600 + alarm_min * 60 + as_[d];
                exp_flags[d][4] = (tod[d] % 60 == 0);
                exp_flags[d][3] = (tod[d] % 3600 == 0);
                exp_flags[d][2] = (tod[d] == 0);
                exp_flags[d][0] = alarm_en && alarm_hour <= 23 && alarm_min <= 59 &&
                                  tod[d] == target;
            end
        end
    endtask

    task automatic step(input logic r, input logic t, input logic l,
                        input int lh, input int lm, input int ls);
        rst = r; tick_en = t; load_en = l;
        load_hour = 5'(lh); load_min = 6'(lm); load_sec = 6'(ls);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("disp%0d", d), 32'(obs_disp(d)), 32'(exp_disp(tod[d], mode_24)));
            chk($sformatf("flags%0d", d), 32'(obs_flags(d)), 32'(exp_flags[d]));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        td[0] = TD0; rh[0] = RH0; as_[0] = AS0;
        td[1] = TD1; rh[1] = RH1; as_[1] = AS1;
        tod[0] = 0; tod[1] = 0; presc[0] = 0; presc[1] = 0;
        mode_24 = 1'b1; alarm_en = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;

        // Reset state in both display modes.
        step(1'b1, 1'b1, 1'b1, 3, 4, 5);
        chk("rst_disp24", 32'(obs_disp(0)), {7'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
        mode_24 = 1'b0;
        #1;
        chk("rst_disp12", 32'(obs_disp(0)), {7'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
        mode_24 = 1'b1;
        idle(2);

        // Day wrap from 23:59:58.
        step(1'b0, 1'b0, 1'b1, 23, 59, 58);
        tick(1);
        chk("wrap_pre", 32'(obs_disp(0)), {7'd0, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b1});
        tick(1);
        chk("wrap_post", 32'(obs_disp(0)), 32'd0);
        chk("wrap_flags", 32'(obs_flags(0)), 32'b11100);
        idle(1);
        chk("wrap_flags_gone", 32'(obs_flags(0)), 32'd0);

        // Prescaler of four from 00:00:00.
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        tick(3);
        chk("div4_hold", 32'(s1[1]), 32'd0);
        tick(1);
        chk("div4_first", 32'(s1[1]), 32'd1);
        tick(4);
        chk("div4_second", 32'(s1[1]), 32'd2);
        tick(2);
        idle(3);

        // 12-hour display.
        mode_24 = 1'b0;
        step(1'b0, 1'b0, 1'b1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 12, 30, 0);
        chk("h12_noon", 32'(obs_disp(0)), {7'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 1'b1});
        step(1'b0, 1'b0, 1'b1, 13, 5, 7);
        chk("h12_pm1", 32'(obs_disp(0)), {7'd0, 4'd0, 4'd1, 4'd0, 4'd5, 4'd0, 4'd7, 1'b1});
        mode_24 = 1'b1;
        idle(1);

        // Rejected loads with a concurrent tick.
        step(1'b0, 1'b1, 1'b1, 24, 0, 0);
        chk("lerr_hour", 32'(load_err[0]), 32'd1);
        step(1'b0, 1'b1, 1'b1, 10, 60, 0);
        step(1'b0, 1'b1, 1'b1, 10, 0, 63);
        idle(2);

        // Alarm at 07:30 (DUT0 seconds 0, DUT1 seconds 3).
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        step(1'b0, 1'b0, 1'b1, 7, 29, 59);
        tick(1);
        chk("alarm_fire", 32'(alarm[0]), 32'd1);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 7, 30, 0);
        chk("alarm_on_load", 32'(alarm[0]), 32'd0);
        tick(16);
        alarm_hour = 5'd30;
        step(1'b0, 1'b0, 1'b1, 7, 29, 59);
        tick(2);
        alarm_en = 1'b0;

        // Reset overriding a load and a tick at 10:59:59.
        step(1'b0, 1'b0, 1'b1, 10, 59, 59);
        step(1'b1, 1'b1, 1'b1, 10, 59, 59);
        chk("rst_over0", 32'(obs_disp(0)), 32'd0);
        chk("rst_over1", 32'(obs_disp(1)), {7'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r, nt;
            logic rr, tt, ll;
            r  = int'($urandom_range(0, 99));
            rr = (r == 0);
            ll = (r >= 1 && r < 7);
            tt = ($urandom_range(0, 3) != 0);
            mode_24  = 1'($urandom);
            alarm_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                nt = (tod[0] + 1) % 86400;
                alarm_hour = 5'(nt / 3600);
                alarm_min  = 6'((nt / 60) % 60);
            end else begin
                alarm_hour = 5'($urandom);
                alarm_min  = 6'($urandom);
            end
            if ($urandom_range(0, 2) == 0)
                step(rr, tt, ll, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)));
            else
                step(rr, tt, ll, int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                     int'($urandom_range(50, 59)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
